// File: rtl/fault_recovery_pkg.sv
// Shared state encoding and default timing constants for the fault recovery supervisor.
package fault_recovery_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RESET_HOLD = 2'd1,
    ST_HOLDOFF    = 2'd2,
    ST_SAFE       = 2'd3
  } state_e;

  localparam int unsigned DEF_RST_CYCLES     = 4;
  localparam int unsigned DEF_HOLDOFF_CYCLES = 8;
  localparam int unsigned DEF_MAX_RETRIES    = 2;
  localparam int unsigned DEF_CNT_LENGTH     = 4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fault_recovery_timer.sv
// Loadable down-counter shared by the reset-hold and holdoff phases.
module recovery_timer #(
  parameter int unsigned MAX_VAL = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           load,
  input  logic [$clog2(MAX_VAL+1)-1:0]   load_val,
  output logic                           done_c
);

  localparam int unsigned W = $clog2(MAX_VAL + 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_c = (count_q == '0);

endmodule

// File: rtl/fault_recovery.sv
// Watchdog-driven subsystem supervisor: bounded reset retries, then latched safe mode.
module fault_recovery
  import fault_recovery_pkg::*;
#(
  parameter int unsigned RST_CYCLES     = DEF_RST_CYCLES,
  parameter int unsigned HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int unsigned MAX_RETRIES    = DEF_MAX_RETRIES,
  parameter int unsigned CNT_LENGTH     = DEF_CNT_LENGTH
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 timeout,
  input  logic                                 heartbeat_ok,
  input  logic                                 clear_fault,
  output logic                                 sub_reset_n,
  output logic                                 wd_kick,
  output logic                                 safe_mode,
  output logic [$clog2(MAX_RETRIES+1)-1:0]     retry_count,
  output logic [CNT_LENGTH-1:0]                fault_total
);

  localparam int unsigned RC_W    = $clog2(MAX_RETRIES + 1);
  localparam int unsigned TMR_MAX = max_u(RST_CYCLES, HOLDOFF_CYCLES);
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  state_e               state_q, state_d;
  logic [RC_W-1:0]      retry_q, retry_d;
  logic [CNT_LENGTH-1:0] fault_q, fault_d;
  logic                 sub_reset_n_q, sub_reset_n_d;
  logic                 wd_kick_q, wd_kick_d;
  logic                 safe_mode_q, safe_mode_d;
  logic                 tmr_load;
  logic [TMR_W-1:0]     tmr_val;
  logic                 tmr_done_c;

  recovery_timer #(
    .MAX_VAL (TMR_MAX)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done_c   (tmr_done_c)
  );

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    fault_d  = fault_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      ST_IDLE: begin
        // timeout outranks a coincident heartbeat
        if (timeout) begin
          if (fault_q != '1) begin
            fault_d = fault_q + CNT_LENGTH'(1);
          end
          if (retry_q < RC_W'(MAX_RETRIES)) begin
            state_d  = ST_RESET_HOLD;
            retry_d  = retry_q + RC_W'(1);
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(RST_CYCLES - 1);
          end else begin
            state_d = ST_SAFE;
          end
        end else if (heartbeat_ok) begin
          retry_d = '0;
        end
      end
      ST_RESET_HOLD: begin
        if (tmr_done_c) begin
          state_d  = ST_HOLDOFF;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(HOLDOFF_CYCLES - 1);
        end
      end
      ST_HOLDOFF: begin
        if (tmr_done_c) begin
          state_d = ST_IDLE;
        end
      end
      ST_SAFE: begin
        if (clear_fault) begin
          state_d = ST_IDLE;
          retry_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they align with it
    sub_reset_n_d = !((state_d == ST_RESET_HOLD) || (state_d == ST_SAFE));
    wd_kick_d     = (state_d != ST_IDLE);
    safe_mode_d   = (state_d == ST_SAFE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      retry_q       <= '0;
      fault_q       <= '0;
      sub_reset_n_q <= 1'b1;
      wd_kick_q     <= 1'b0;
      safe_mode_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      retry_q       <= retry_d;
      fault_q       <= fault_d;
      sub_reset_n_q <= sub_reset_n_d;
      wd_kick_q     <= wd_kick_d;
      safe_mode_q   <= safe_mode_d;
    end
  end

  assign sub_reset_n = sub_reset_n_q;
  assign wd_kick     = wd_kick_q;
  assign safe_mode   = safe_mode_q;
  assign retry_count = retry_q;
  assign fault_total = fault_q;

endmodule

// File: doc/fault_recovery.md
FAULT_RECOVERY -- requirements
Module: fault_recovery

Interface
REQ-001 Parameter RST_CYCLES, default 4: cycles sub_reset_n is held low per recovery attempt; SHALL be >=1.
REQ-002 Parameter HOLDOFF_CYCLES, default 8: post-reset boot window cycles; SHALL be >=1.
REQ-003 Parameter MAX_RETRIES, default 2: consecutive recoveries allowed before safe mode; SHALL be >=1.
REQ-004 Parameter CNT_LENGTH, default 4: width of fault_total.
REQ-005 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 timeout  input  1  watchdog expiry flag, active high; may be a level or a pulse.
REQ-008 heartbeat_ok  input  1  one-cycle pulse from the subsystem confirming healthy operation.
REQ-009 clear_fault  input  1  operator pulse that releases safe mode.
REQ-010 sub_reset_n  output  1  active-low reset to the supervised subsystem.
REQ-011 wd_kick  output  1  kick to the watchdog; holds the watchdog cleared during recovery.
REQ-012 safe_mode  output  1  high while latched in SAFE.
REQ-013 retry_count  output  clog2(MAX_RETRIES+1)  consecutive-timeout count.
REQ-014 fault_total  output  CNT_LENGTH  lifetime timeout count, saturating.

Function
REQ-015 The FSM SHALL have four states: IDLE, RESET_HOLD, HOLDOFF and SAFE; all outputs SHALL be registered.
REQ-016 IDLE: sub_reset_n=1, wd_kick=0, safe_mode=0.
REQ-017 IDLE with timeout=1 and retry_count<MAX_RETRIES: the FSM SHALL go to RESET_HOLD on the next edge and increment retry_count.
REQ-018 IDLE with timeout=1 and retry_count==MAX_RETRIES: the FSM SHALL go to SAFE on the next edge; retry_count SHALL hold.
REQ-019 Every timeout accepted in IDLE SHALL increment fault_total, saturating at all-ones with no wrap-around.
REQ-020 RESET_HOLD: sub_reset_n=0 and wd_kick=1 for exactly RST_CYCLES cycles, then go to HOLDOFF.
REQ-021 HOLDOFF: sub_reset_n=1 and wd_kick=1 for exactly HOLDOFF_CYCLES cycles, then go to IDLE.
REQ-022 SAFE: sub_reset_n=0, wd_kick=1 and safe_mode=1, held indefinitely.
REQ-023 SAFE with clear_fault=1: the FSM SHALL go to IDLE on the next edge, clear retry_count to 0 and leave fault_total unchanged.
REQ-024 heartbeat_ok=1 in IDLE SHALL clear retry_count to 0 on the next edge.
REQ-025 timeout=1 and heartbeat_ok=1 in the same IDLE cycle: timeout SHALL win and heartbeat_ok SHALL be ignored.
REQ-026 timeout and heartbeat_ok SHALL be ignored in RESET_HOLD, HOLDOFF and SAFE.
REQ-027 clear_fault SHALL be ignored outside SAFE.
REQ-028 Latency: timeout sampled at edge N SHALL produce sub_reset_n=0 and wd_kick=1 at edge N+1.

Reset
REQ-029 reset_n=0 SHALL immediately force, without waiting for a clock edge: state=IDLE, sub_reset_n=1, wd_kick=0, safe_mode=0, retry_count=0, fault_total=0, phase timer=0.
REQ-030 Reset asserted mid-recovery or in SAFE SHALL abandon the sequence; after release the block SHALL operate normally from IDLE.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (2-bit, IDLE=0, RESET_HOLD=1, HOLDOFF=2, SAFE=3) and the default timing constants.
REQ-032 A sub-module recovery_timer SHALL provide the phase timing: a loadable down-counter sized for max(RST_CYCLES, HOLDOFF_CYCLES), with a load/value input and a done output; it SHALL be instantiated once and shared by RESET_HOLD and HOLDOFF.

Verification
All scenarios use defaults (RST_CYCLES=4, HOLDOFF_CYCLES=8, MAX_RETRIES=2, CNT_LENGTH=4).
REQ-033 Single timeout pulse at cycle 10 -> sub_reset_n=0 for cycles 11-14; wd_kick=1 for cycles 11-22; IDLE at cycle 23; retry_count=1; fault_total=1.
REQ-034 Three timeouts, each after recovery completes, with no heartbeat -> third timeout enters SAFE; safe_mode=1; sub_reset_n stays 0; retry_count=2; fault_total=3; clear_fault pulse -> IDLE, retry_count=0, fault_total=3.
REQ-035 Timeout and heartbeat_ok asserted in the same IDLE cycle -> recovery starts; retry_count increments to 1, not cleared.
REQ-036 reset_n asserted at the 2nd RESET_HOLD cycle -> sub_reset_n=1 and wd_kick=0 with no clock edge; state=IDLE; all counters 0.
REQ-037 20 timeouts, each followed by heartbeat_ok after recovery -> fault_total saturates at 15; retry_count never exceeds 1; SAFE never entered.
REQ-038 Timeout held high through an entire recovery -> no retrigger during RESET_HOLD or HOLDOFF; a new recovery starts on the first IDLE cycle it is still high.
